id_hazard_unit: RTL and testbench
=================================

# id_hazard_unit

Tracks the destination registers of instructions in flight in EX, MEM and WB, and drives the register file's bypass inputs (forward data plus per-source hazard flags). Detects load-use hazards and asserts a one-cycle stall toward IF/ID. Sits beside the ID stage: it consumes decoded ID fields and the EX/MEM/WB result buses, and feeds the register file read path.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `NREG_W`, 5, register index width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `id_rs1` / `id_rs2`  in  5  source register indices of the instruction in ID.
- `id_rs1_used` / `id_rs2_used`  in  1  source actually read by the ID instruction.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rd`  in  5  destination register of the ID instruction.
- `id_we`  in  1  ID instruction writes `id_rd`.
- `id_is_load`  in  1  ID instruction is a load.
- `flush`  in  1  taken branch or jump resolved in EX; kills the ID instruction.
- `ext_stall`  in  1  memory-side freeze; holds all tracking slots.
- `ex_result`  in  XLEN  ALU result of the EX instruction (same cycle).
- `mem_result`  in  XLEN  final value of the MEM instruction (load data or ALU result).
- `wb_result`  in  XLEN  value being written back this cycle.
- `forward_rD1` / `forward_rD2`  out  XLEN  bypass data for rs1/rs2.
- `rs1_id_data_hazard` / `rs2_id_data_hazard`  out  1  select bypass data for rs1/rs2.
- `load_use_stall`  out  1  hold PC and IF/ID; insert a bubble into EX.

## Operation
- Three tracking slots, EX, MEM and WB, each holding {valid, rd, we, is_load}. A slot is live when valid && we && rd != 0.
- Source match: rsN_used && rsN != 0 && a live slot with rd == rsN.
- Priority is EX > MEM > WB. The youngest match wins and supplies ex_result, mem_result or wb_result.
- A WB match is forwarded because the register file commits only at the edge.
- Load-use: the EX slot is live, is_load = 1, and it matches a used source. `load_use_stall` = 1.
  - During a load-use stall, the hazard flag for that source is 0; the bypass data for it is don't-care.
- No match: hazard flag = 0 and forward data = 0.
- Slot advance at each edge, in priority order:
  - `rst`: all slots invalid.
  - else `ext_stall`: all slots hold.
  - else `flush` or `load_use_stall`: EX ← bubble, MEM ← EX, WB ← MEM.
  - else: EX ← {id_valid, id_rd, id_we, id_is_load}, MEM ← EX, WB ← MEM.
- `flush` overrides `load_use_stall`. When `flush` = 1, `load_use_stall` is forced to 0 because the dependent instruction is killed.
- `ext_stall` does not mask `load_use_stall`. Both may be high together, and the upstream pipeline holds.

## Timing
- All outputs are combinational from the slots plus the current ID/result inputs. There is no output register and the latency is 0 cycles.
- Slots update only on the rising edge of `clk`.
- Reset values: all slots invalid; `load_use_stall` = 0; both hazard flags = 0; both forward outputs = 0 (because all slots are invalid).
- Reset asserted mid-stall clears all slots at the next edge. `load_use_stall` falls in the cycle after that edge.
- A load-use stall lasts exactly 1 cycle when `ext_stall` = 0. On the next cycle the load sits in MEM and is forwarded from `mem_result`.
- Same rd in EX and MEM: the EX value is used. Same rd in MEM and WB: the MEM value is used.

## Configuration
- Macro `HAZARD_STATS_EN`.
- Defined: adds two output ports, `stat_stall_cnt` and `stat_fwd_cnt`, each 32 bits and reset to 0 by `rst`.
  - `stat_stall_cnt` increments on each edge where `load_use_stall` = 1 and `ext_stall` = 0.
  - `stat_fwd_cnt` increments by the number of asserted hazard flags (0, 1 or 2) per edge where `ext_stall` = 0.
  - Both counters wrap modulo 2^32.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- EX forward: issue addi x5 (we=1, rd=5); next cycle an ID instruction reads rs1=5 with ex_result=0x1234 → `rs1_id_data_hazard`=1, `forward_rD1`=0x1234, `load_use_stall`=0.
- Priority: x7 is written by back-to-back instructions in MEM (mem_result=0xA) and EX (ex_result=0xB); ID reads rs2=7 → `forward_rD2`=0xB.
- Load-use: a load to x3 is in EX; ID reads rs1=3 → `load_use_stall`=1 for exactly 1 cycle. The next cycle, with mem_result=0xDEAD, gives hazard=1 and `forward_rD1`=0xDEAD, and the EX slot holds a bubble.
- x0 and unused sources: rd=0 is written in EX, or rs1=5 is matched but `id_rs1_used`=0 → both hazard flags 0 and no stall.
- Flush beats stall: a load to x3 is in EX, ID reads x3, `flush`=1 → `load_use_stall`=0, and after the edge the EX slot is invalid.
- Reset mid-operation: all slots are live and `rst`=1 for one edge → all outputs are 0 afterward. With `HAZARD_STATS_EN` defined, both counters read 0.

Source files
------------

// File: rtl/id_hazard_unit.sv
// ID-stage hazard unit: tracks EX/MEM/WB destinations, drives bypass data and load-use stall.
// Optional HAZARD_STATS_EN adds stall and forward event counters.
module id_hazard_unit #(
  parameter int XLEN   = 32,
  parameter int NREG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREG_W-1:0] id_rs1,
  input  logic [NREG_W-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_valid,
  input  logic [NREG_W-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              ext_stall,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [XLEN-1:0]   wb_result,
  output logic [XLEN-1:0]   forward_rD1,
  output logic [XLEN-1:0]   forward_rD2,
  output logic              rs1_id_data_hazard,
  output logic              rs2_id_data_hazard,
  output logic              load_use_stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stat_stall_cnt,
  output logic [31:0]       stat_fwd_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [NREG_W-1:0] rd;
    logic              we;
    logic              is_load;
  } slot_t;

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d, mem_d, wb_d;

  logic rs1_ex, rs1_mem, rs1_wb;
  logic rs2_ex, rs2_mem, rs2_wb;
  logic lu1, lu2;

  function automatic logic hit(slot_t s, logic used, logic [NREG_W-1:0] rs);
    return used && (rs != '0) && s.valid && s.we && (s.rd != '0) && (s.rd == rs);
  endfunction

  always_comb begin
    rs1_ex  = hit(ex_q,  id_rs1_used, id_rs1);
    rs1_mem = hit(mem_q, id_rs1_used, id_rs1);
    rs1_wb  = hit(wb_q,  id_rs1_used, id_rs1);
    rs2_ex  = hit(ex_q,  id_rs2_used, id_rs2);
    rs2_mem = hit(mem_q, id_rs2_used, id_rs2);
    rs2_wb  = hit(wb_q,  id_rs2_used, id_rs2);
    lu1     = rs1_ex && ex_q.is_load;
    lu2     = rs2_ex && ex_q.is_load;
    // A killed ID instruction cannot consume anything, so flush cancels the stall.
    load_use_stall = (lu1 || lu2) && !flush;
  end

  // Youngest match wins; a load still in EX has no data yet, so its source is not flagged.
  always_comb begin
    rs1_id_data_hazard = 1'b0;
    forward_rD1        = '0;
    if (rs1_ex) begin
      rs1_id_data_hazard = !ex_q.is_load;
      forward_rD1        = ex_q.is_load ? '0 : ex_result;
    end else if (rs1_mem) begin
      rs1_id_data_hazard = 1'b1;
      forward_rD1        = mem_result;
    end else if (rs1_wb) begin
      rs1_id_data_hazard = 1'b1;
      forward_rD1        = wb_result;
    end

    rs2_id_data_hazard = 1'b0;
    forward_rD2        = '0;
    if (rs2_ex) begin
      rs2_id_data_hazard = !ex_q.is_load;
      forward_rD2        = ex_q.is_load ? '0 : ex_result;
    end else if (rs2_mem) begin
      rs2_id_data_hazard = 1'b1;
      forward_rD2        = mem_result;
    end else if (rs2_wb) begin
      rs2_id_data_hazard = 1'b1;
      forward_rD2        = wb_result;
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!ext_stall) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (flush || load_use_stall) begin
        ex_d = '0;
      end else begin
        ex_d = '{valid: id_valid, rd: id_rd, we: id_we, is_load: id_is_load};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (!ext_stall) begin
      stall_cnt_q <= stall_cnt_q + 32'(load_use_stall);
      fwd_cnt_q   <= fwd_cnt_q + 32'(rs1_id_data_hazard) + 32'(rs2_id_data_hazard);
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
  assign stat_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed bench for id_hazard_unit: stimulus queues expectations, a negedge monitor compares.
module tb_id_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_valid, id_we, id_is_load;
  logic        flush, ext_stall;
  logic [31:0] ex_result, mem_result, wb_result;
  logic [31:0] forward_rD1, forward_rD2;
  logic        rs1_id_data_hazard, rs2_id_data_hazard, load_use_stall;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_cnt, stat_fwd_cnt;
`endif

  id_hazard_unit #(.XLEN(32), .NREG_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_valid(id_valid), .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .flush(flush), .ext_stall(ext_stall),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .forward_rD1(forward_rD1), .forward_rD2(forward_rD2),
    .rs1_id_data_hazard(rs1_id_data_hazard), .rs2_id_data_hazard(rs2_id_data_hazard),
    .load_use_stall(load_use_stall)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cnt(stat_stall_cnt), .stat_fwd_cnt(stat_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  // mask bits: {h1, f1, h2, f2, stall}; a cleared bit marks a don't-care field
  typedef struct {
    string       name;
    logic [4:0]  mask;
    logic        h1;
    logic [31:0] f1;
    logic        h2;
    logic [31:0] f2;
    logic        stall;
    bit          statsZero;
  } exp_t;

  exp_t expQ[$];
  bit   checkThis = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                               input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2);
    @(posedge clk);
    #1;
    checkThis   = 1'b0;
    id_valid    = v;
    id_rd       = rd;
    id_we       = we;
    id_is_load  = ld;
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
    flush       = 1'b0;
    ext_stall   = 1'b0;
  endtask

  task automatic setResults(input logic [31:0] ex, input logic [31:0] mem, input logic [31:0] wb);
    ex_result  = ex;
    mem_result = mem;
    wb_result  = wb;
  endtask

  task automatic checkOutput(input string nm, input logic h1, input logic [31:0] f1,
                             input logic h2, input logic [31:0] f2, input logic st,
                             input logic [4:0] mask = 5'b11111, input bit statsZero = 1'b0);
    exp_t e;
    e.name = nm; e.mask = mask; e.h1 = h1; e.f1 = f1; e.h2 = h2; e.f2 = f2;
    e.stall = st; e.statsZero = statsZero;
    expQ.push_back(e);
    checkThis = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    bit   bad;
    forever begin
      @(negedge clk);
      if (checkThis) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL monitor: output sampled with no queued expectation");
        end else begin
          e   = expQ.pop_front();
          bad = (e.mask[4] && rs1_id_data_hazard !== e.h1) ||
                (e.mask[3] && forward_rD1 !== e.f1) ||
                (e.mask[2] && rs2_id_data_hazard !== e.h2) ||
                (e.mask[1] && forward_rD2 !== e.f2) ||
                (e.mask[0] && load_use_stall !== e.stall);
`ifdef HAZARD_STATS_EN
          if (e.statsZero && (stat_stall_cnt !== 32'd0 || stat_fwd_cnt !== 32'd0)) bad = 1'b1;
`endif
          if (bad) begin
            errors++;
            $display("[TB] FAIL %s: got h1=%0b f1=%h h2=%0b f2=%h stall=%0b, want h1=%0b f1=%h h2=%0b f2=%h stall=%0b mask=%b",
                     e.name, rs1_id_data_hazard, forward_rD1, rs2_id_data_hazard, forward_rD2,
                     load_use_stall, e.h1, e.f1, e.h2, e.f2, e.stall, e.mask);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    rst = 1'b1;
    id_valid = 0; id_rd = 0; id_we = 0; id_is_load = 0;
    id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
    flush = 0; ext_stall = 0;
    setResults(32'h0, 32'h0, 32'h0);

    // reset state: nothing live, reads of x5 see no hazard
    applyStimulus(1, 5'd1, 1, 0, 5'd5, 1, 5'd5, 1);
    setResults(32'h1111, 32'h2222, 32'h3333);
    checkOutput("reset_state", 0, 0, 0, 0, 0);

    // A: addi x5
    applyStimulus(1, 5'd5, 1, 0, 5'd0, 0, 5'd0, 0);
    rst = 1'b0;
    checkOutput("empty_pipe", 0, 0, 0, 0, 0);

    // B: reads x5 from EX, writes x6
    applyStimulus(1, 5'd6, 1, 0, 5'd5, 1, 5'd0, 0);
    setResults(32'h1234, 32'hAAAA0001, 32'hBBBB0001);
    checkOutput("ex_forward", 1, 32'h1234, 0, 0, 0);

    // C: store reads x5 from MEM
    applyStimulus(1, 5'd0, 0, 0, 5'd0, 0, 5'd5, 1);
    setResults(32'h7777, 32'h5555, 32'hBBBB0002);
    checkOutput("mem_forward", 0, 0, 1, 32'h5555, 0);

    // D: x5 from WB and x6 from MEM, writes x7
    applyStimulus(1, 5'd7, 1, 0, 5'd5, 1, 5'd6, 1);
    setResults(32'hEEEE0003, 32'h6666, 32'h9999);
    checkOutput("wb_and_mem", 1, 32'h9999, 1, 32'h6666, 0);

    // E: writes x7 again
    applyStimulus(1, 5'd7, 1, 0, 5'd0, 0, 5'd0, 0);

    // F: x7 in EX and MEM, rs1 names x7 but is unused
    applyStimulus(1, 5'd0, 0, 0, 5'd7, 0, 5'd7, 1);
    setResults(32'hB, 32'hA, 32'hC);
    checkOutput("ex_over_mem", 0, 0, 1, 32'hB, 0);

    // G: x7 in MEM and WB
    applyStimulus(0, 5'd0, 0, 0, 5'd7, 1, 5'd0, 0);
    setResults(32'h1, 32'h22, 32'h33);
    checkOutput("mem_over_wb", 1, 32'h22, 0, 0, 0);

    // H: load x3
    applyStimulus(1, 5'd3, 1, 1, 5'd0, 0, 5'd0, 0);
    checkOutput("load_issue", 0, 0, 0, 0, 0);

    // I: add x8 reads x3 while load in EX
    applyStimulus(1, 5'd8, 1, 0, 5'd3, 1, 5'd0, 0);
    setResults(32'hBEEF, 32'h0, 32'h0);
    checkOutput("load_use_stall", 0, 0, 0, 0, 1, 5'b10111);

    // J: held add, load now in MEM
    applyStimulus(1, 5'd8, 1, 0, 5'd3, 1, 5'd0, 0);
    setResults(32'hBEEF, 32'hDEAD, 32'h0);
    checkOutput("load_mem_fwd", 1, 32'hDEAD, 0, 0, 0);

    // K: add x8 reached EX; ID writes x0
    applyStimulus(1, 5'd0, 1, 0, 5'd8, 1, 5'd0, 0);
    setResults(32'h88, 32'h1, 32'h2);
    checkOutput("after_stall_ex", 1, 32'h88, 0, 0, 0);

    // L: x0 write in EX, x8 in MEM but rs1 unused
    applyStimulus(0, 5'd0, 0, 0, 5'd8, 0, 5'd0, 1);
    setResults(32'h10, 32'h20, 32'h30);
    checkOutput("x0_and_unused", 0, 0, 0, 0, 0);

    // M: load x3
    applyStimulus(1, 5'd3, 1, 1, 5'd0, 0, 5'd0, 0);
    checkOutput("load_issue2", 0, 0, 0, 0, 0);

    // N: dependent read with flush
    applyStimulus(1, 5'd9, 1, 0, 5'd3, 1, 5'd0, 0);
    flush = 1'b1;
    checkOutput("flush_beats_stall", 0, 0, 0, 0, 0, 5'b00111);

    // O: EX must be a bubble; load now in MEM
    applyStimulus(0, 5'd0, 0, 0, 5'd9, 1, 5'd3, 1);
    setResults(32'h9999, 32'h3333, 32'h4444);
    checkOutput("flush_bubble", 0, 0, 1, 32'h3333, 0);

    // P: load x4
    applyStimulus(1, 5'd4, 1, 1, 5'd0, 0, 5'd0, 0);
    checkOutput("load_issue3", 0, 0, 0, 0, 0);

    // Q: load-use while memory-side freeze
    applyStimulus(1, 5'd10, 1, 0, 5'd4, 1, 5'd0, 0);
    ext_stall = 1'b1;
    checkOutput("stall_with_ext", 0, 0, 0, 0, 1, 5'b10111);

    // R: freeze released; slots held so stall persists
    applyStimulus(1, 5'd10, 1, 0, 5'd4, 1, 5'd0, 0);
    checkOutput("stall_after_ext", 0, 0, 0, 0, 1, 5'b10111);

    // S: load forwarded from MEM
    applyStimulus(1, 5'd10, 1, 0, 5'd4, 1, 5'd0, 0);
    setResults(32'h5, 32'h44, 32'h6);
    checkOutput("ext_then_fwd", 1, 32'h44, 0, 0, 0);

    // T, U: fill pipe (x11, load x12)
    applyStimulus(1, 5'd11, 1, 0, 5'd0, 0, 5'd0, 0);
    applyStimulus(1, 5'd12, 1, 1, 5'd0, 0, 5'd0, 0);

    // V: all slots live, load-use active, reset asserted
    applyStimulus(1, 5'd13, 1, 0, 5'd12, 1, 5'd10, 1);
    setResults(32'hC, 32'hB0, 32'hA0);
    rst = 1'b1;
    checkOutput("pre_reset", 0, 0, 1, 32'hA0, 1, 5'b10111);

    // W: slots cleared by reset edge
    applyStimulus(1, 5'd13, 1, 0, 5'd12, 1, 5'd10, 1);
    rst = 1'b0;
    checkOutput("post_reset", 0, 0, 0, 0, 0, 5'b11111, 1'b1);

    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
    for (int i = 0; i < 5 && expQ.size() != 0; i++) @(posedge clk);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations never checked, want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
